weight_loader: RTL and testbench
================================

Name: weight_loader

Overview:
- Upstream feeder for the per-bank weight memories.
- Accepts a per-layer weight byte stream over a valid/ready handshake and issues synthesizable write-port transactions (csen, wrenb, addr_b, data_b, layer2weight_cnt) to NUM_BANKS weight banks.
- Interleaves bytes round-robin across banks so all banks are filled in one pass.
- Signals completion to the layer controller, which then starts convolution reads.

Parameters:
- ADDR_WIDTH, 11, per-bank write address width.
- DATA_WIDTH, 8, weight byte width.
- DATA_DEPTH, 2048, words per bank.
- NUM_BANKS, 2, number of banks; power of two, at least 1.
- LEN_WIDTH, 16, width of the byte-count input.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to load one layer; sampled only in IDLE.
- layer_id  in  4  layer index (1-8); latched on an accepted start.
- num_bytes  in  LEN_WIDTH  total bytes for the layer; latched on an accepted start.
- abort  in  1  cancel the current load.
- s_valid  in  1  stream byte valid.
- s_data  in  DATA_WIDTH  stream byte.
- s_ready  out  1  loader can accept a byte.
- csen  out  NUM_BANKS  one-hot bank chip select.
- wrenb  out  1  write strobe to the banks.
- addr_b  out  ADDR_WIDTH  bank write address.
- data_b  out  DATA_WIDTH  write data.
- layer2weight_cnt  out  4  latched layer index, held stable for the whole load.
- busy  out  1  high in LOAD and DONE.
- done  out  1  one-cycle pulse when the load completes.
- err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; all outputs 0, including s_ready, csen, wrenb, addr_b, data_b, layer2weight_cnt, busy, done and err; byte counter cleared. Reset mid-load discards the load and issues no done.
- States: IDLE, LOAD, DONE.
- IDLE, s_ready=0. On start:
  - num_bytes > NUM_BANKS*DATA_DEPTH: err=1 for the next cycle; stay in IDLE; layer2weight_cnt unchanged.
  - num_bytes == 0: layer2weight_cnt<=layer_id; go to DONE with no write.
  - Otherwise: latch layer_id and num_bytes; cnt<=0; go to LOAD.
- LOAD: s_ready=1 (combinational from state; no dependence on s_valid).
  - Handshake means s_valid and s_ready high at a rising edge.
  - At handshake edge T, for the next cycle: wrenb<=1, data_b<=s_data, csen<=one-hot(cnt mod NUM_BANKS), addr_b<=cnt/NUM_BANKS, cnt<=cnt+1.
  - No handshake at an edge: wrenb<=0, csen<=0. addr_b and data_b hold their values.
  - Handshake on byte num_bytes-1: state<=DONE; s_ready drops from the next cycle.
- DONE: the final write is visible during this cycle when num_bytes>0. On the next edge: wrenb<=0, csen<=0, done<=1 for one cycle, state<=IDLE.
- Write latency: exactly 1 cycle from accepting a byte to its write strobe. Sustained throughput is 1 byte per clock.
- abort, sampled in LOAD: if a handshake occurs on the same edge, that byte is dropped and not written. wrenb<=0, csen<=0, state<=IDLE, no done. Already written bytes stay in memory.
- abort in IDLE or DONE: ignored.
- start while busy: ignored; no err.
- abort and start on the same edge in IDLE: start wins.
- layer2weight_cnt holds its last value after done until the next accepted start.
- Arithmetic:
  - cnt is LEN_WIDTH bits wide.
  - Bank index is the low log2(NUM_BANKS) bits of cnt; address is the remaining upper bits, truncated to ADDR_WIDTH.
  - The oversize check guarantees the address never exceeds DATA_DEPTH-1.
  - With NUM_BANKS=1, csen is constant 1 during writes.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 3 of 6 bytes written -> all outputs 0 immediately; after release, s_ready=0 and done never pulses.
- Normal load, NUM_BANKS=2: start, layer_id=3, num_bytes=6, bytes 0xA0..0xA5 back-to-back -> six consecutive wrenb cycles, each 1 cycle after its handshake:
  - csen: 01,10,01,10,01,10.
  - addr_b: 0,0,1,1,2,2.
  - data_b matches each byte.
  - layer2weight_cnt=3 throughout.
  - done pulses 1 cycle after the last write.
- Backpressure gaps: s_valid toggled 1,0,0,1,0,1 for num_bytes=3 -> wrenb only after valid cycles; addresses are not consumed by idle cycles; done after the third write.
- Zero and oversize: num_bytes=0 -> done 2 cycles after start, with no wrenb. num_bytes=4097 -> err pulse, busy stays 0, no writes.
- Abort: num_bytes=8; abort asserted on the same edge as the 4th handshake -> exactly 3 writes, 4th byte absent, no done; a fresh start is then accepted.
- Start while busy: second start with layer_id=5 during LOAD -> ignored; layer2weight_cnt stays at its first value; no err.

Source files
------------

// File: rtl/weight_loader.sv
// weight_loader: streams one layer's weight bytes round-robin into NUM_BANKS
// weight banks, one write per accepted byte, then pulses done for the layer controller.
module weight_loader #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DATA_DEPTH = 2048,
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            layer_id,
  input  logic [LEN_WIDTH-1:0]  num_bytes,
  input  logic                  abort,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [NUM_BANKS-1:0]  csen,
  output logic                  wrenb,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] data_b,
  output logic [3:0]            layer2weight_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  localparam int unsigned BankBits = $clog2(NUM_BANKS);
  localparam int unsigned MaxBytes = NUM_BANKS * DATA_DEPTH;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [3:0]            r_layer;
  logic                  r_wrenb;
  logic [NUM_BANKS-1:0]  r_csen;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_done;
  logic                  r_err;

  logic                  w_oversize;
  logic                  w_zero;
  logic                  w_hs;
  logic                  w_last;
  logic [LEN_WIDTH-1:0]  w_bank;
  logic [NUM_BANKS-1:0]  w_csen_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;

  assign w_oversize = 32'(num_bytes) > MaxBytes;
  assign w_zero     = (num_bytes == '0);
  assign w_hs       = s_valid && (r_state == StLoad);
  assign w_last     = (r_cnt == r_len - LEN_WIDTH'(1));
  // Low bits of the byte count pick the bank, the rest form the in-bank address.
  assign w_bank     = r_cnt & LEN_WIDTH'(NUM_BANKS - 1);
  assign w_csen_nxt = NUM_BANKS'(1) << w_bank;
  assign w_addr_nxt = ADDR_WIDTH'(r_cnt >> BankBits);

  assign s_ready          = (r_state == StLoad);
  assign busy             = (r_state != StIdle);
  assign csen             = r_csen;
  assign wrenb            = r_wrenb;
  assign addr_b           = r_addr;
  assign data_b           = r_data;
  assign layer2weight_cnt = r_layer;
  assign done             = r_done;
  assign err              = r_err;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; abort only matters while loading, start only while idle.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (start && !w_oversize) w_state_nxt = w_zero ? StDone : StLoad;
      end
      StLoad: begin
        if (abort)              w_state_nxt = StIdle;
        else if (w_hs && w_last) w_state_nxt = StDone;
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Datapath: latch the request, issue one bank write per accepted byte, pulse flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_len   <= '0;
      r_layer <= '0;
      r_wrenb <= 1'b0;
      r_csen  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_wrenb <= 1'b0;
          r_csen  <= '0;
          if (start) begin
            if (w_oversize) begin
              r_err <= 1'b1;
            end else begin
              r_layer <= layer_id;
              r_len   <= num_bytes;
              r_cnt   <= '0;
            end
          end
        end
        StLoad: begin
          if (!abort && w_hs) begin
            r_wrenb <= 1'b1;
            r_csen  <= w_csen_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= s_data;
            r_cnt   <= r_cnt + LEN_WIDTH'(1);
          end else begin
            // A byte accepted on an abort edge is dropped.
            r_wrenb <= 1'b0;
            r_csen  <= '0;
          end
        end
        StDone: begin
          r_wrenb <= 1'b0;
          r_csen  <= '0;
          r_done  <= 1'b1;
        end
        default: begin
          r_wrenb <= 1'b0;
          r_csen  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: accepted bytes queue their expected bank write,
// a negedge monitor pops and compares every write the DUT strobes.
module tb_weight_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  layer_id;
  logic [15:0] num_bytes;
  logic        abort;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic [1:0]  csen;
  logic        wrenb;
  logic [10:0] addr_b;
  logic [7:0]  data_b;
  logic [3:0]  layer2weight_cnt;
  logic        busy;
  logic        done;
  logic        err;

  weight_loader dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .layer_id         (layer_id),
    .num_bytes        (num_bytes),
    .abort            (abort),
    .s_valid          (s_valid),
    .s_data           (s_data),
    .s_ready          (s_ready),
    .csen             (csen),
    .wrenb            (wrenb),
    .addr_b           (addr_b),
    .data_b           (data_b),
    .layer2weight_cnt (layer2weight_cnt),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int csen;
    int addr;
    int data;
    int layer;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   idx = 0;
  int   exp_layer = 0;
  int   n_wr = 0;
  int   n_done = 0;
  int   n_errp = 0;
  int   done_cyc = -1;
  int   last_wr_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: check strobed writes first, then record any handshake due on the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin n_done++; done_cyc = cyc; end
      if (err) n_errp++;
      if (wrenb) begin
        n_wr++;
        last_wr_cyc = cyc;
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected none", addr_b, data_b);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("wr_csen", int'(csen), e.csen);
          chk("wr_addr", int'(addr_b), e.addr);
          chk("wr_data", int'(data_b), e.data);
          chk("wr_layer", int'(layer2weight_cnt), e.layer);
          chk("wr_latency_cycle", cyc, e.cyc);
        end
      end
      if (s_valid && s_ready && !abort) begin
        exp_t e;
        e.csen  = 1 << (idx % 2);
        e.addr  = idx / 2;
        e.data  = int'(s_data);
        e.layer = exp_layer;
        e.cyc   = cyc + 1;
        q.push_back(e);
        idx++;
      end
    end
  end

  // Pulse start for one cycle; 'accepted' is the hand-decided outcome.
  task automatic do_start(input int lid, input int nb, input bit accepted);
    start = 1'b1;
    layer_id = 4'(lid);
    num_bytes = 16'(nb);
    if (accepted) begin
      exp_layer = lid;
      idx = 0;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive(input bit v, input int d);
    s_valid = v;
    s_data = 8'(d);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int wr0, dn0, er0, sc;
  bit bp_v[6] = '{1, 0, 0, 1, 0, 1};
  int bp_d[6] = '{'hB0, 'h11, 'h22, 'hB1, 'h33, 'hB2};

  initial begin
    rst_n = 1'b0; start = 1'b0; layer_id = '0; num_bytes = '0;
    abort = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wrenb", int'(wrenb), 0);
    chk("rst_layer", int'(layer2weight_cnt), 0);
    rst_n = 1'b1;
    idle(2);

    // Normal back-to-back load of six bytes.
    wr0 = n_wr; dn0 = n_done;
    do_start(3, 6, 1);
    chk("load_s_ready", int'(s_ready), 1);
    chk("load_busy", int'(busy), 1);
    for (int i = 0; i < 6; i++) drive(1'b1, 'hA0 + i);
    idle(4);
    chk("normal_writes", n_wr - wr0, 6);
    chk("normal_done", n_done - dn0, 1);
    chk("normal_done_timing", done_cyc, last_wr_cyc + 1);
    chk("normal_layer_after", int'(layer2weight_cnt), 3);
    chk("normal_idle_ready", int'(s_ready), 0);

    // Backpressure gaps do not consume addresses.
    wr0 = n_wr; dn0 = n_done;
    do_start(2, 3, 1);
    for (int i = 0; i < 6; i++) drive(bp_v[i], bp_d[i]);
    idle(4);
    chk("bp_writes", n_wr - wr0, 3);
    chk("bp_done", n_done - dn0, 1);
    chk("bp_done_timing", done_cyc, last_wr_cyc + 1);

    // Zero-length load.
    wr0 = n_wr; dn0 = n_done;
    sc = cyc;
    do_start(7, 0, 1);
    idle(4);
    chk("zero_writes", n_wr - wr0, 0);
    chk("zero_done", n_done - dn0, 1);
    chk("zero_done_timing", done_cyc, sc + 2);
    chk("zero_layer", int'(layer2weight_cnt), 7);

    // Oversize request rejected.
    wr0 = n_wr; dn0 = n_done; er0 = n_errp;
    do_start(9, 4097, 0);
    chk("over_busy", int'(busy), 0);
    chk("over_err_pulse", int'(err), 1);
    idle(3);
    chk("over_err_count", n_errp - er0, 1);
    chk("over_writes", n_wr - wr0, 0);
    chk("over_done", n_done - dn0, 0);
    chk("over_layer_kept", int'(layer2weight_cnt), 7);

    // Abort on the 4th handshake drops that byte.
    wr0 = n_wr; dn0 = n_done;
    do_start(4, 8, 1);
    for (int i = 0; i < 3; i++) drive(1'b1, 'hC0 + i);
    abort = 1'b1;
    drive(1'b1, 'hC3);
    abort = 1'b0;
    idle(4);
    chk("abort_writes", n_wr - wr0, 3);
    chk("abort_no_done", n_done - dn0, 0);
    chk("abort_busy", int'(busy), 0);
    wr0 = n_wr; dn0 = n_done;
    do_start(6, 2, 1);
    drive(1'b1, 'hD0);
    drive(1'b1, 'hD1);
    idle(4);
    chk("post_abort_writes", n_wr - wr0, 2);
    chk("post_abort_done", n_done - dn0, 1);

    // Start while busy is ignored.
    wr0 = n_wr; dn0 = n_done; er0 = n_errp;
    do_start(1, 4, 1);
    drive(1'b1, 'hE0);
    drive(1'b1, 'hE1);
    start = 1'b1; layer_id = 4'd5; num_bytes = 16'd3;
    drive(1'b1, 'hE2);
    start = 1'b0;
    chk("busy_start_layer", int'(layer2weight_cnt), 1);
    drive(1'b1, 'hE3);
    idle(4);
    chk("busy_start_writes", n_wr - wr0, 4);
    chk("busy_start_done", n_done - dn0, 1);
    chk("busy_start_no_err", n_errp - er0, 0);
    chk("busy_start_layer_end", int'(layer2weight_cnt), 1);

    // Reset mid-load after 3 of 6 bytes.
    wr0 = n_wr; dn0 = n_done;
    do_start(3, 6, 1);
    for (int i = 0; i < 3; i++) drive(1'b1, 'hF0 + i);
    s_valid = 1'b0;
    @(negedge clk); #1;
    chk("midrst_writes_before", n_wr - wr0, 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_wrenb", int'(wrenb), 0);
    chk("midrst_csen", int'(csen), 0);
    chk("midrst_addr", int'(addr_b), 0);
    chk("midrst_data", int'(data_b), 0);
    chk("midrst_layer", int'(layer2weight_cnt), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_s_ready", int'(s_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    chk("postrst_s_ready", int'(s_ready), 0);
    chk("postrst_no_done", n_done - dn0, 0);
    chk("postrst_writes", n_wr - wr0, 3);
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
